mmu_arbiter: RTL and testbench
==============================

// Module: mmu_arbiter
// PURPOSE
//  Multi-channel memory management unit between the cache line buses and main memory.
//  - Serialises line-wide read/write requests from CHANNELS caches (default: I$ and D$) onto one memory bus.
//  - Arbitration is round-robin; each transaction is tagged with a source id.
//  - A watchdog aborts stalled transactions.
// PARAMETERS
//  CHANNELS  2    number of cache-side requesters (>=1)
//  WIDTH     256  cache line / memory data width, bits
//  XLEN      32   address width, bits
//  TIMEOUT   1024 max cycles in ISSUE+WAIT before abort; 0 = watchdog disabled
// PORTS
//  clk          in   1              clock; all logic on rising edge
//  reset_n      in   1              asynchronous, active-low reset
//  ch_read      in   CHANNELS       per-channel line read request, level, held until ch_done
//  ch_write     in   CHANNELS       per-channel line write request, level, held until ch_done
//  ch_address   in   CHANNELS*XLEN  per-channel line address, stable while request held
//  ch_wdata     in   CHANNELS*WIDTH per-channel write line, stable while request held
//  ch_ready     out  CHANNELS       1-cycle pulse: request granted and latched
//  ch_done      out  CHANNELS       1-cycle pulse: transaction complete
//  ch_err       out  CHANNELS       1-cycle pulse with ch_done: transaction aborted by watchdog
//  ch_rdata     out  WIDTH          read line, shared; valid only in the ch_done cycle
//  mem_read     out  1              memory read strobe, held until mem_ready
//  mem_write    out  1              memory write strobe, held until mem_ready
//  mem_address  out  XLEN           latched address of the granted request
//  mem_wdata    out  WIDTH          latched write line
//  mem_source   out  $clog2(CHANNELS) id of granted channel (1 bit when CHANNELS==1)
//  mem_rdata    in   WIDTH          read line from memory, valid with mem_done
//  mem_ready    in   1              memory accepted the strobe
//  mem_done     in   1              memory finished the transaction
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last_grant = CHANNELS-1 (channel 0 wins first), watchdog 0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//  - IDLE: req[i] = ch_read[i] | ch_write[i].
//    - If any req: pick the first requester at or after last_grant+1 (mod CHANNELS).
//    - Latch address, wdata, op and id; pulse ch_ready[g]; go to ISSUE.
//    - A write has priority over a read when both are set on one channel (op = write).
//  - ISSUE: drive mem_read or mem_write plus address, wdata and source.
//    - mem_ready=1 and mem_done=0: go to WAIT.
//    - mem_ready=1 and mem_done=1 in the same cycle: go straight to RESP, capturing mem_rdata.
//    - Strobe deasserts the cycle after mem_ready is seen.
//  - WAIT: strobes 0. On mem_done, capture mem_rdata into a register and go to RESP.
//  - RESP: ch_done[g]=1 for one cycle; ch_rdata = captured line (reads), 0 for writes; last_grant <= g.
//  Requesters drop their request on the edge ending ch_done, so IDLE never re-grants a completed transaction.
//  Minimum latency, request visible to ch_done: 3 cycles (IDLE, ISSUE, RESP).
//  Watchdog: counts every cycle in ISSUE/WAIT.
//  - Reaching TIMEOUT forces RESP with ch_err[g]=1 and ch_rdata=0; strobes drop immediately.
//  - mem_done/mem_ready arriving in IDLE or RESP are ignored.
//  Only one transaction is outstanding; requests from other channels wait, unacknowledged.
//  A request deasserted before grant is legal and is simply dropped.
//  Async reset mid-transaction returns to IDLE at once; any memory response after reset is ignored.
//  ch_ready, ch_done and ch_err are registered, never combinational from inputs.
//  mem_* outputs are registered.
// STRUCTURE
//  mmu_pkg: typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mmu_state_e;
//  mmu_pkg: typedef enum logic {OP_READ, OP_WRITE} mmu_op_e.
//  Sub-module rr_arbiter #(N): req[N], last[$clog2(N)] -> grant one-hot plus index; purely combinational.
//  Top: FSM, request latch, watchdog counter, rdata capture register.
// TESTING
//  1 Ch0 read 0x1000; memory ready@+1, done@+3 with 0xAA..AA -> ch_ready[0] once, ch_done[0] with rdata 0xAA..AA, mem_source=0.
//  2 Ch0 and ch1 read in the same cycle, repeated 4 times -> grants alternate 0,1,0,1, none starved.
//  3 Ch1 write 0x2040 with data 0x55..55 -> mem_write=1, mem_wdata=0x55..55, mem_source=1, ch_done[1]=1, ch_rdata=0.
//  4 TIMEOUT=16, memory never asserts mem_done -> ch_done[0] and ch_err[0] 16 cycles after ISSUE; a late mem_done is ignored.
//  5 mem_ready and mem_done in the same ISSUE cycle -> ch_done exactly 3 cycles after the request.
//  6 reset_n low while in WAIT -> outputs 0 within the same cycle; after release, ch0 is granted first.

Source files
------------

// File: rtl/mmu_pkg.sv
// ----------------------------------------------------------------------------
// mmu_pkg
//   Shared types for the memory management unit arbiter.
//   - mmu_state_e : transaction FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   - mmu_op_e    : latched operation of the granted request
//   - idx_width() : width of a channel index (at least 1 bit)
// ----------------------------------------------------------------------------
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mmu_state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mmu_op_e;

    // Channel index width; a single channel still needs one bit of source id.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmu_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin selector. The winner is the first
//   requester found at or after (i_last + 1) mod N.
// Ports
//   i_req   [N-1:0]  request vector
//   i_last  [IW-1:0] index of the previously completed grant
//   o_grant [N-1:0]  one-hot grant (all zero when no request)
//   o_idx   [IW-1:0] index of the granted requester
//   o_any   1        at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
    import mmu_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int unsigned w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        // Walk the ring starting just after the last grant; the first hit wins.
        for (int unsigned off = 1; off <= N; off++) begin
            w_cand = (32'(i_last) + off) % N;
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/mmu_arbiter.sv
// ----------------------------------------------------------------------------
// mmu_arbiter
//   Serialises line-wide read/write requests from CHANNELS caches onto a
//   single memory bus. Round-robin arbitration, one outstanding transaction,
//   source-id tagging and a watchdog that aborts stalled transactions.
// Parameters
//   CHANNELS  number of cache-side requesters (>= 1)
//   WIDTH     line / memory data width in bits
//   XLEN      address width in bits
//   TIMEOUT   max cycles spent in ISSUE+WAIT before abort; 0 disables
// Ports
//   clk, reset_n                  clock (rising edge), async active-low reset
//   ch_read/ch_write  [CH]        level requests, held until ch_done
//   ch_address        [CH*XLEN]   per-channel line address
//   ch_wdata          [CH*WIDTH]  per-channel write line
//   ch_ready          [CH]        pulse: request granted and latched
//   ch_done/ch_err    [CH]        pulse: completion / watchdog abort
//   ch_rdata          [WIDTH]     read line, valid in the ch_done cycle
//   mem_read/mem_write            strobes, held until mem_ready
//   mem_address/mem_wdata         latched request fields
//   mem_source                    granted channel id
//   mem_rdata/mem_ready/mem_done  memory response
// ----------------------------------------------------------------------------
module mmu_arbiter
    import mmu_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 256,
    parameter int XLEN     = 32,
    parameter int TIMEOUT  = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CHANNELS-1:0]           ch_read,
    input  logic [CHANNELS-1:0]           ch_write,
    input  logic [CHANNELS*XLEN-1:0]      ch_address,
    input  logic [CHANNELS*WIDTH-1:0]     ch_wdata,
    output logic [CHANNELS-1:0]           ch_ready,
    output logic [CHANNELS-1:0]           ch_done,
    output logic [CHANNELS-1:0]           ch_err,
    output logic [WIDTH-1:0]              ch_rdata,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [XLEN-1:0]               mem_address,
    output logic [WIDTH-1:0]              mem_wdata,
    output logic [idx_width(CHANNELS)-1:0] mem_source,
    input  logic [WIDTH-1:0]              mem_rdata,
    input  logic                          mem_ready,
    input  logic                          mem_done
);

    localparam int SW      = idx_width(CHANNELS);
    localparam int WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [SW-1:0] LAST_INIT = SW'(CHANNELS - 1);

    mmu_state_e          r_state;
    mmu_op_e             r_op;
    logic [SW-1:0]       r_gnt;
    logic [SW-1:0]       r_last;
    logic [WDW-1:0]      r_wd;
    logic [WIDTH-1:0]    r_rdata;

    logic [CHANNELS-1:0] w_req;
    logic [CHANNELS-1:0] w_grant;
    logic [SW-1:0]       w_idx;
    logic                w_any;
    logic                w_wd_hit;
    logic                w_complete;

    assign w_req = ch_read | ch_write;

    rr_arbiter #(
        .N  (CHANNELS),
        .IW (SW)
    ) u_rr (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // r_wd == TIMEOUT-1 marks the TIMEOUT-th cycle spent in ISSUE/WAIT.
    assign w_wd_hit   = (TIMEOUT != 0) && (r_wd == WDW'(WD_LAST));
    // mem_done only completes in ISSUE when paired with mem_ready.
    assign w_complete = mem_done && ((r_state == WAIT) || mem_ready);

    // The capture register doubles as the shared read-data output; it is
    // cleared when RESP ends so stale data never lingers.
    assign ch_rdata = r_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_op        <= OP_READ;
            r_gnt       <= '0;
            r_last      <= LAST_INIT;
            r_wd        <= '0;
            r_rdata     <= '0;
            ch_ready    <= '0;
            ch_done     <= '0;
            ch_err      <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_source  <= '0;
        end else begin
            ch_ready <= '0;
            ch_done  <= '0;
            ch_err   <= '0;

            case (r_state)
                IDLE: begin
                    r_wd <= '0;
                    if (w_any) begin
                        r_gnt       <= w_idx;
                        mem_source  <= w_idx;
                        mem_address <= ch_address[w_idx*XLEN +: XLEN];
                        mem_wdata   <= ch_wdata[w_idx*WIDTH +: WIDTH];
                        ch_ready    <= w_grant;
                        // Write wins when both strobes are set on one channel.
                        if (ch_write[w_idx]) begin
                            r_op      <= OP_WRITE;
                            mem_write <= 1'b1;
                        end else begin
                            r_op      <= OP_READ;
                            mem_read  <= 1'b1;
                        end
                        r_state <= ISSUE;
                    end
                end

                ISSUE, WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    // A genuine completion in the last watchdog cycle still
                    // counts as a normal completion.
                    if (w_complete) begin
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        r_rdata        <= (r_op == OP_READ) ? mem_rdata : '0;
                        ch_done[r_gnt] <= 1'b1;
                        r_state        <= RESP;
                    end else if (w_wd_hit) begin
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        r_rdata        <= '0;
                        ch_done[r_gnt] <= 1'b1;
                        ch_err[r_gnt]  <= 1'b1;
                        r_state        <= RESP;
                    end else if ((r_state == ISSUE) && mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        r_state   <= WAIT;
                    end
                end

                RESP: begin
                    r_rdata <= '0;
                    r_last  <= r_gnt;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_arbiter.sv
module tb_mmu_arbiter;
    import mmu_pkg::*;

    localparam int C   = 2;
    localparam int W   = 256;
    localparam int XL  = 32;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [C-1:0]    ch_read, ch_write;
    logic [C*XL-1:0] ch_address;
    logic [C*W-1:0]  ch_wdata;
    logic [C-1:0]    ch_ready, ch_done, ch_err;
    logic [W-1:0]    ch_rdata;
    logic            mem_read, mem_write;
    logic [XL-1:0]   mem_address;
    logic [W-1:0]    mem_wdata;
    logic [0:0]      mem_source;
    logic [W-1:0]    mem_rdata;
    logic            mem_ready, mem_done;

    mmu_arbiter #(
        .CHANNELS (C),
        .WIDTH    (W),
        .XLEN     (XL),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ch_read     (ch_read),
        .ch_write    (ch_write),
        .ch_address  (ch_address),
        .ch_wdata    (ch_wdata),
        .ch_ready    (ch_ready),
        .ch_done     (ch_done),
        .ch_err      (ch_err),
        .ch_rdata    (ch_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_source  (mem_source),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_done    (mem_done)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Per-channel scenario description consumed by round().
    logic [C-1:0]  rq_rd, rq_wr;
    logic [XL-1:0] t_addr [C];
    logic [W-1:0]  t_data [C];
    logic [W-1:0]  t_mem  [C];
    int            t_rd   [C];   // ISSUE cycles before mem_ready
    int            t_dd   [C];   // cycles from mem_ready to mem_done
    bit            t_late [C];   // drive a stray response in the RESP cycle
    int            last_g;       // reference model: last completed grant

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_defaults();
        rq_rd = '0;
        rq_wr = '0;
        for (int i = 0; i < C; i++) begin
            t_addr[i] = $urandom & 32'hFFFF_FFE0;
            t_data[i] = rand_line();
            t_mem[i]  = rand_line();
            t_rd[i]   = 0;
            t_dd[i]   = 0;
            t_late[i] = 1'b0;
        end
    endtask

    // Serve every request in rq_rd|rq_wr. Called at a sample point (#1 after
    // a rising edge); each loop pass first checks the cycle, then drives it.
    task automatic round();
        logic [C-1:0] pend;
        logic [C-1:0] oh;
        int           w, resp_c;
        bit           err, wr, s;
        pend       = rq_rd | rq_wr;
        ch_read    = rq_rd;
        ch_write   = rq_wr;
        for (int i = 0; i < C; i++) begin
            ch_address[i*XL +: XL] = t_addr[i];
            ch_wdata[i*W +: W]     = t_data[i];
        end
        while (pend != '0) begin
            w = -1;
            for (int k = 1; k <= C; k++) begin
                int cand;
                cand = (last_g + k) % C;
                if (w < 0 && pend[cand]) w = cand;
            end
            oh    = '0;
            oh[w] = 1'b1;
            wr    = rq_wr[w];
            // Cycles needed in ISSUE+WAIT = t_rd + t_dd + 1; beyond TMO aborts.
            err    = (t_rd[w] + t_dd[w] + 1) > TMO;
            resp_c = err ? (1 + TMO) : (2 + t_rd[w] + t_dd[w]);
            for (int c = 0; c <= resp_c; c++) begin
                s = (c >= 1) && (c <= 1 + t_rd[w]) && (c < resp_c);
                check("ch_ready", ch_ready, (c == 1) ? oh : '0);
                check("mem_read", mem_read, s && !wr);
                check("mem_write", mem_write, s && wr);
                check("ch_done", ch_done, (c == resp_c) ? oh : '0);
                check("ch_err", ch_err, (c == resp_c && err) ? oh : '0);
                if (c == 1) begin
                    check("mem_source", mem_source, W'(w));
                    check("mem_address", mem_address, t_addr[w]);
                    if (wr) check("mem_wdata", mem_wdata, t_data[w]);
                end
                if (c == resp_c)
                    check("ch_rdata", ch_rdata, (!err && !wr) ? t_mem[w] : '0);
                mem_ready = (c == 1 + t_rd[w]) && (c < resp_c);
                mem_done  = !err && (c == 1 + t_rd[w] + t_dd[w]);
                if (err && t_late[w] && c == resp_c) begin
                    mem_ready = 1'b1;
                    mem_done  = 1'b1;
                end
                mem_rdata = mem_done ? t_mem[w] : rand_line();
                if (c == resp_c) begin
                    ch_read[w]  = 1'b0;
                    ch_write[w] = 1'b0;
                    pend[w]     = 1'b0;
                    last_g      = w;
                end
                @(posedge clk); #1;
            end
        end
        mem_ready = 1'b0;
        mem_done  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n    = 1'b0;
        ch_read    = '0;
        ch_write   = '0;
        ch_address = '0;
        ch_wdata   = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        mem_done   = 1'b0;
        last_g     = C - 1;
        set_defaults();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ch_ready", ch_ready, '0);
        check("rst_ch_done", ch_done, '0);
        check("rst_ch_err", ch_err, '0);
        check("rst_ch_rdata", ch_rdata, '0);
        check("rst_mem_read", mem_read, '0);
        check("rst_mem_write", mem_write, '0);
        check("rst_mem_address", mem_address, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_mem_source", mem_source, '0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // Ch0 read 0x1000, ready one cycle into ISSUE, done two cycles later
        set_defaults();
        rq_rd     = 2'b01;
        t_addr[0] = 32'h0000_1000;
        t_mem[0]  = {8{32'hAAAA_AAAA}};
        t_rd[0]   = 1;
        t_dd[0]   = 2;
        round();

        // Both channels read together, four times: grants must alternate
        repeat (4) begin
            set_defaults();
            rq_rd   = 2'b11;
            t_rd[0] = $urandom_range(0, 2);
            t_dd[0] = $urandom_range(0, 3);
            t_rd[1] = $urandom_range(0, 2);
            t_dd[1] = $urandom_range(0, 3);
            round();
        end

        // Ch1 write 0x2040 with 0x55..55
        set_defaults();
        rq_wr     = 2'b10;
        t_addr[1] = 32'h0000_2040;
        t_data[1] = {8{32'h5555_5555}};
        t_rd[1]   = 1;
        t_dd[1]   = 1;
        round();

        // Watchdog abort: memory accepts but never finishes; stray response in RESP
        set_defaults();
        rq_rd     = 2'b01;
        t_rd[0]   = 0;
        t_dd[0]   = 100;
        t_late[0] = 1'b1;
        round();
        // A late response arriving in IDLE must be ignored
        mem_ready = 1'b1;
        mem_done  = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("late_ch_done", ch_done, '0);
            check("late_mem_read", mem_read, '0);
        end
        mem_ready = 1'b0;
        mem_done  = 1'b0;

        // Ready and done in the same ISSUE cycle: done on the third cycle
        set_defaults();
        rq_rd   = 2'b01;
        t_rd[0] = 0;
        t_dd[0] = 0;
        round();

        // Reset while in WAIT
        ch_read                = 2'b01;
        ch_address[0 +: XL]    = 32'h0000_3000;
        @(posedge clk); #1;
        check("rstw_issue_read", mem_read, 1'b1);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        check("rstw_wait_read", mem_read, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rstw_ch_ready", ch_ready, '0);
        check("rstw_ch_done", ch_done, '0);
        check("rstw_mem_read", mem_read, '0);
        check("rstw_mem_write", mem_write, '0);
        check("rstw_mem_address", mem_address, '0);
        check("rstw_mem_source", mem_source, '0);
        check("rstw_ch_rdata", ch_rdata, '0);
        ch_read   = '0;
        mem_done  = 1'b1;
        mem_rdata = rand_line();
        @(posedge clk); #1;
        check("rstw_hold_done", ch_done, '0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rstw_post_done", ch_done, '0);
        check("rstw_post_read", mem_read, '0);
        mem_done = 1'b0;
        last_g   = C - 1;
        set_defaults();
        rq_rd = 2'b11;
        t_rd[0] = 1;
        t_dd[0] = 1;
        round();

        // Randomised traffic
        repeat (30) begin
            set_defaults();
            for (int i = 0; i < C; i++) begin
                rq_rd[i]  = $urandom_range(0, 1);
                rq_wr[i]  = $urandom_range(0, 1);
                t_rd[i]   = $urandom_range(0, 3);
                t_dd[i]   = $urandom_range(0, 5);
                if ($urandom_range(0, 7) == 0) t_dd[i] = 30;
                t_late[i] = $urandom_range(0, 1);
            end
            if ((rq_rd | rq_wr) == '0) rq_rd[0] = 1'b1;
            round();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                check("gap_ch_done", ch_done, '0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
